// File: rtl/ri_cpu_controller.sv
// Multi-cycle sequencer for the R/I-type datapath: fetches into ir, decodes
// into ALU/register-file controls and retires one instruction per 3+ROM_LAT cycles.
module ri_cpu_controller #(
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned RET_W   = 32
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             en,
    input  logic [31:0]      inst,
    output logic [31:0]      ir,
    output logic             pc_we,
    output logic             rf_we,
    output logic             rf_dst_sel,
    output logic             alu_b_sel,
    output logic             imm_zext,
    output logic [3:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                                OP_OR  = 4'd3, OP_XOR = 4'd4, OP_NOR = 4'd5,
                                OP_SLT = 4'd6, OP_SLL = 4'd7, OP_SRL = 4'd8,
                                OP_LUI = 4'd9;

    state_t            st, nxt;
    logic [CNT_W-1:0]  wait_cnt, cnt_nxt;
    logic              fetch_done;

    logic [31:0]       ir_nxt;
    logic              we_nxt, dst_nxt, bsel_nxt, zext_nxt, ill_nxt;
    logic [OP_W-1:0]   op_nxt;
    logic [RET_W-1:0]  ret_nxt;

    logic              dec_ok, dec_dst, dec_bsel, dec_zext;
    logic [OP_W-1:0]   dec_op;
    logic [5:0]        opcode, funct;

    assign opcode     = ir[31:26];
    assign funct      = ir[5:0];
    assign fetch_done = (wait_cnt == CNT_W'(ROM_LAT - 1));
    assign state      = st;

    // State and output registers
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            st         <= S_IDLE;
            wait_cnt   <= '0;
            ir         <= '0;
            pc_we      <= 1'b0;
            rf_we      <= 1'b0;
            rf_dst_sel <= 1'b0;
            alu_b_sel  <= 1'b0;
            imm_zext   <= 1'b0;
            alu_op     <= '0;
            illegal    <= 1'b0;
            retired    <= '0;
        end else begin
            st         <= nxt;
            wait_cnt   <= cnt_nxt;
            ir         <= ir_nxt;
            pc_we      <= we_nxt;
            rf_we      <= we_nxt;
            rf_dst_sel <= dst_nxt;
            alu_b_sel  <= bsel_nxt;
            imm_zext   <= zext_nxt;
            alu_op     <= op_nxt;
            illegal    <= ill_nxt;
            retired    <= ret_nxt;
        end
    end

    // Instruction decode tables
    always_comb begin
        dec_ok   = 1'b1;
        dec_dst  = 1'b0;
        dec_bsel = 1'b1;
        dec_zext = 1'b0;
        dec_op   = OP_ADD;
        if (opcode == 6'h00) begin
            dec_dst  = 1'b1;
            dec_bsel = 1'b0;
            case (funct)
                6'h20:   dec_op = OP_ADD;
                6'h22:   dec_op = OP_SUB;
                6'h24:   dec_op = OP_AND;
                6'h25:   dec_op = OP_OR;
                6'h26:   dec_op = OP_XOR;
                6'h27:   dec_op = OP_NOR;
                6'h2A:   dec_op = OP_SLT;
                6'h00:   dec_op = OP_SLL;
                6'h02:   dec_op = OP_SRL;
                default: dec_ok = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h08:   dec_op = OP_ADD;
                6'h0A:   dec_op = OP_SLT;
                6'h0C:   begin dec_op = OP_AND; dec_zext = 1'b1; end
                6'h0D:   begin dec_op = OP_OR;  dec_zext = 1'b1; end
                6'h0E:   begin dec_op = OP_XOR; dec_zext = 1'b1; end
                6'h0F:   begin dec_op = OP_LUI; dec_zext = 1'b1; end
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // Next-state logic; the fetch wait counter only runs in FETCH
    always_comb begin
        nxt     = st;
        cnt_nxt = '0;
        case (st)
            S_IDLE:   if (en) nxt = S_FETCH;
            S_FETCH: begin
                if (fetch_done) nxt = S_DECODE;
                else            cnt_nxt = wait_cnt + CNT_W'(1);
            end
            S_DECODE: nxt = dec_ok ? S_EXEC : S_HALT;
            S_EXEC:   nxt = S_WB;
            S_WB:     nxt = en ? S_FETCH : S_IDLE;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        ir_nxt   = ir;
        dst_nxt  = rf_dst_sel;
        bsel_nxt = alu_b_sel;
        zext_nxt = imm_zext;
        op_nxt   = alu_op;
        ill_nxt  = illegal;
        ret_nxt  = retired;
        we_nxt   = (nxt == S_WB);
        if (st == S_FETCH && fetch_done) ir_nxt = inst;
        if (st == S_DECODE) begin
            if (dec_ok) begin
                dst_nxt  = dec_dst;
                bsel_nxt = dec_bsel;
                zext_nxt = dec_zext;
                op_nxt   = dec_op;
            end else begin
                ill_nxt = 1'b1;
            end
        end
        if (st == S_WB) ret_nxt = retired + RET_W'(1);
    end

endmodule

// File: tb/tb_ri_cpu_controller.sv
// Bench for ri_cpu_controller: two instances (ROM_LAT=1/RET_W=32 and ROM_LAT=3/RET_W=4)
// compared every cycle against an instruction-phase model, plus literal checks.
module tb_ri_cpu_controller;

    localparam int unsigned LAT_A = 1, RETW_A = 32;
    localparam int unsigned LAT_B = 3, RETW_B = 4;
    localparam logic [31:0] I_ADD = 32'h0043_0820, I_LUI = 32'h3C01_ABCD,
                            I_ORI = 32'h3421_FFFF, I_ADDI = 32'h2001_FFFF,
                            I_BAD = 32'hFC00_0000;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rst_a = 1'b0, en_a = 1'b0, rst_b = 1'b0, en_b = 1'b0;
    logic [31:0] inst_a = '0, inst_b = '0;
    logic [31:0] ir_a, ir_b, retired_a;
    logic [3:0]  op_a, op_b, retired_b;
    logic [2:0]  state_a, state_b;
    logic        pc_we_a, rf_we_a, dst_a, bsel_a, zext_a, ill_a;
    logic        pc_we_b, rf_we_b, dst_b, bsel_b, zext_b, ill_b;

    ri_cpu_controller #(.ROM_LAT(LAT_A), .RET_W(RETW_A)) dut_a (
        .clka(clka), .rsta(rst_a), .en(en_a), .inst(inst_a), .ir(ir_a),
        .pc_we(pc_we_a), .rf_we(rf_we_a), .rf_dst_sel(dst_a), .alu_b_sel(bsel_a),
        .imm_zext(zext_a), .alu_op(op_a), .state(state_a), .illegal(ill_a),
        .retired(retired_a));

    ri_cpu_controller #(.ROM_LAT(LAT_B), .RET_W(RETW_B)) dut_b (
        .clka(clka), .rsta(rst_b), .en(en_b), .inst(inst_b), .ir(ir_b),
        .pc_we(pc_we_b), .rf_we(rf_we_b), .rf_dst_sel(dst_b), .alu_b_sel(bsel_b),
        .imm_zext(zext_b), .alu_op(op_b), .state(state_b), .illegal(ill_b),
        .retired(retired_b));

    // Model: mode 0 idle / 1 running / 2 halted; k = cycle index within the instruction
    typedef struct packed {
        int          mode;
        int          k;
        logic [31:0] ir;
        logic        dst, bsel, zext, ill;
        logic [3:0]  op;
        longint      ret;
    } mdl_t;

    mdl_t m_a, m_b;
    int   checks = 0, errors = 0;
    bit   cmp_on = 1'b0;

    function automatic mdl_t mreset();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    function automatic logic decode(input logic [31:0] w, output logic [3:0] op,
                                    output logic dst, output logic bsel, output logic zext);
        logic [5:0] opc, fn;
        opc = w[31:26]; fn = w[5:0];
        op = 4'd0; dst = 1'b0; bsel = 1'b1; zext = 1'b0;
        if (opc == 6'h00) begin
            dst = 1'b1; bsel = 1'b0;
            case (fn)
                6'h20: op = 4'd0;  6'h22: op = 4'd1;  6'h24: op = 4'd2;
                6'h25: op = 4'd3;  6'h26: op = 4'd4;  6'h27: op = 4'd5;
                6'h2A: op = 4'd6;  6'h00: op = 4'd7;  6'h02: op = 4'd8;
                default: return 1'b0;
            endcase
            return 1'b1;
        end
        case (opc)
            6'h08: op = 4'd0;
            6'h0A: op = 4'd6;
            6'h0C: begin op = 4'd2; zext = 1'b1; end
            6'h0D: begin op = 4'd3; zext = 1'b1; end
            6'h0E: begin op = 4'd4; zext = 1'b1; end
            6'h0F: begin op = 4'd9; zext = 1'b1; end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int lat, input logic en,
                                  input logic [31:0] inst);
        mdl_t n;
        logic [3:0] op;
        logic d, b, z;
        n = m;
        if (m.mode == 0) begin
            if (en) begin n.mode = 1; n.k = 0; end
        end else if (m.mode == 1) begin
            if (m.k < lat) begin
                if (m.k == lat - 1) n.ir = inst;
                n.k = m.k + 1;
            end else if (m.k == lat) begin
                if (decode(m.ir, op, d, b, z)) begin
                    n.op = op; n.dst = d; n.bsel = b; n.zext = z; n.k = m.k + 1;
                end else begin
                    n.ill = 1'b1; n.mode = 2;
                end
            end else if (m.k == lat + 1) begin
                n.k = m.k + 1;
            end else begin
                n.ret = m.ret + 1;
                if (en) n.k = 0; else n.mode = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [76:0] expv(input mdl_t m, input int lat, input int retw);
        int st;
        logic wb;
        logic [31:0] r;
        if (m.mode == 0)      st = 0;
        else if (m.mode == 2) st = 5;
        else if (m.k < lat)   st = 1;
        else                  st = 2 + (m.k - lat);
        wb = (m.mode == 1) && (m.k == lat + 2);
        r  = 32'(m.ret & ((64'd1 << retw) - 64'd1));
        return {3'(st), m.ir, wb, wb, m.dst, m.bsel, m.zext, m.op, m.ill, r};
    endfunction

    always @(posedge clka or posedge rst_a)
        if (rst_a) m_a <= mreset(); else m_a <= step(m_a, LAT_A, en_a, inst_a);
    always @(posedge clka or posedge rst_b)
        if (rst_b) m_b <= mreset(); else m_b <= step(m_b, LAT_B, en_b, inst_b);

    // Per-cycle comparison of every output against the model
    always @(negedge clka) begin
        logic [76:0] da, db, ea, eb;
        if (cmp_on) begin
            da = {state_a, ir_a, pc_we_a, rf_we_a, dst_a, bsel_a, zext_a, op_a, ill_a, retired_a};
            db = {state_b, ir_b, pc_we_b, rf_we_b, dst_b, bsel_b, zext_b, op_b, ill_b, 28'd0, retired_b};
            ea = expv(m_a, LAT_A, RETW_A);
            eb = expv(m_b, LAT_B, RETW_B);
            checks++;
            if (da !== ea) begin
                errors++;
                $display("FAIL model_a t=%0t got=%h expected=%h", $time, da, ea);
            end
            checks++;
            if (db !== eb) begin
                errors++;
                $display("FAIL model_b t=%0t got=%h expected=%h", $time, db, eb);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fl [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
        logic [5:0] ol [6] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = int'($urandom_range(0, 19));
        if (sel == 0) return r;
        if (sel < 10) return {6'h00, r[25:6], fl[$urandom_range(0, 8)]};
        return {ol[$urandom_range(0, 5)], r[25:0]};
    endfunction

    task automatic run_a();
        #1 rst_a = 1'b1;
        repeat (3) @(negedge clka);
        chk("a_reset_state", 64'(state_a), 0);
        chk("a_reset_ir", 64'(ir_a), 0);
        chk("a_reset_retired", 64'(retired_a), 0);
        chk("a_reset_we", 64'({pc_we_a, rf_we_a, ill_a}), 0);
        #1 rst_a = 1'b0; en_a = 1'b1; inst_a = I_ADD;
        repeat (4) @(negedge clka);
        chk("a_add_wb_state", 64'(state_a), 4);
        chk("a_add_wb_we", 64'({pc_we_a, rf_we_a}), 3);
        chk("a_add_dst", 64'(dst_a), 1);
        chk("a_add_op", 64'(op_a), 0);
        @(negedge clka);
        chk("a_retired_1", 64'(retired_a), 1);
        repeat (4) @(negedge clka);
        chk("a_retired_2", 64'(retired_a), 2);
        #1 inst_a = I_LUI;
        repeat (3) @(negedge clka);
        chk("a_lui_ctl", 64'({bsel_a, zext_a, op_a}), {2'b11, 4'd9});
        @(negedge clka);
        #1 inst_a = I_ORI;
        repeat (3) @(negedge clka);
        chk("a_ori_ctl", 64'({dst_a, zext_a, op_a}), {2'b01, 4'd3});
        @(negedge clka);
        #1 inst_a = I_ADDI;
        repeat (3) @(negedge clka);
        chk("a_addi_ctl", 64'({bsel_a, zext_a, op_a}), {2'b10, 4'd0});
        @(negedge clka);
        #1 inst_a = I_ADD;
        repeat (2) @(negedge clka);
        chk("a_exec_state", 64'(state_a), 3);
        #1 en_a = 1'b0;
        @(negedge clka);
        chk("a_wb_after_drop", 64'(state_a), 4);
        @(negedge clka);
        chk("a_idle_after_drop", 64'(state_a), 0);
        chk("a_retired_6", 64'(retired_a), 6);
        repeat (2) @(negedge clka);
        #1 en_a = 1'b1;
        @(negedge clka);
        chk("a_refetch", 64'(state_a), 1);
        #1 inst_a = I_BAD;
        @(negedge clka);
        @(negedge clka);
        chk("a_illegal", 64'({ill_a, state_a}), {1'b1, 3'd5});
        repeat (20) @(negedge clka);
        chk("a_halt_hold", 64'({ill_a, state_a, pc_we_a, rf_we_a}), {1'b1, 3'd5, 2'b00});
        #1 rst_a = 1'b1;
        @(negedge clka);
        chk("a_halt_reset", 64'({ill_a, state_a, retired_a}), 0);
        #1 rst_a = 1'b0; inst_a = I_ADD;
        repeat (7) @(negedge clka);
        chk("a_exec_pre_rst", 64'({state_a, retired_a}), {3'd3, 32'd1});
        #1 rst_a = 1'b1;
        #2 chk("a_mid_rst", 64'({state_a, retired_a, rf_we_a, pc_we_a}), 0);
        chk("a_mid_rst_ir", 64'(ir_a), 0);
        @(negedge clka);
        #1 rst_a = 1'b0;
        repeat (600) begin
            @(negedge clka);
            #1;
            en_a   = ($urandom_range(0, 9) != 0);
            inst_a = rand_inst();
            rst_a  = (m_a.mode == 2 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
        end
        #1 rst_a = 1'b0;
    endtask

    task automatic run_b();
        int n, last;
        #1 rst_b = 1'b1;
        repeat (2) @(negedge clka);
        #1 rst_b = 1'b0; en_b = 1'b1; inst_b = I_ADD;
        n = 0; last = 0;
        for (int c = 0; c < 200 && n < 17; c++) begin
            @(negedge clka);
            if (pc_we_b) begin
                n++;
                if (n == 1) chk("b_first_wb", 64'(c), 5);
                else        chk("b_spacing", 64'(c - last), 6);
                if (n == 16) chk("b_retired_15", 64'(retired_b), 15);
                if (n == 17) chk("b_retired_wrap", 64'(retired_b), 0);
                last = c;
            end
        end
        chk("b_pulse_count", 64'(n), 17);
        @(negedge clka);
        chk("b_retired_after17", 64'(retired_b), 1);
        repeat (300) begin
            @(negedge clka);
            #1;
            en_b   = ($urandom_range(0, 7) != 0);
            inst_b = rand_inst();
            rst_b  = (m_b.mode == 2 && $urandom_range(0, 3) == 0);
        end
        #1 rst_b = 1'b0;
    endtask

    initial begin
        #2 cmp_on = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            run_a();
            run_b();
        join
        @(negedge clka);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ri_cpu_controller.md
Name: ri_cpu_controller

Overview:
Multi-cycle sequencing controller for the R/I-type CPU datapath. It steps the program counter, captures the instruction word from the instruction ROM, decodes R-type and I-type opcodes into ALU and register-file controls, and retires one instruction every four cycles (ROM_LAT=1). It sits between the program counter / instruction ROM and the register file / ALU.

Parameters:
ROM_LAT, 1, instruction ROM read latency in cycles; number of FETCH cycles per instruction (legal range 1..4)
RET_W, 32, width of the retired-instruction counter

Ports:
clka  input  1  system clock; all state changes on the rising edge
rsta  input  1  asynchronous, active-high reset
en  input  1  run enable; sampled in IDLE and WB
inst  input  32  instruction ROM data out, addressed by the current PC
ir  output  32  instruction register
pc_we  output  1  PC advance strobe; PC steps by 4 on the edge ending a pc_we cycle
rf_we  output  1  register-file write enable
rf_dst_sel  output  1  write-register select: 0 = rt (ir[20:16]), 1 = rd (ir[15:11])
alu_b_sel  output  1  ALU B operand select: 0 = register rt, 1 = immediate
imm_zext  output  1  immediate extension: 1 = zero-extend, 0 = sign-extend
alu_op  output  4  ALU operation code
state  output  3  current FSM state, for debug
illegal  output  1  sticky flag: undecodable instruction
retired  output  RET_W  count of completed instructions

Behaviour:
- Reset (asynchronous, any state): state=IDLE. ir, alu_op and retired are 0. All enables, selects and illegal are 0. Reset takes effect mid-instruction with no write-back.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- IDLE: if en=1, go to FETCH, else stay.
- FETCH: held for ROM_LAT cycles using an internal wait counter. On the edge ending the last FETCH cycle, ir <= inst. Next state is DECODE.
- DECODE: decode ir into registered rf_dst_sel, alu_b_sel, imm_zext and alu_op.
  - If the opcode/funct is not in the tables below, set illegal=1 and go to HALT.
  - Otherwise go to EXEC.
- EXEC: controls are stable for one full cycle (ALU settles). Next state is WB.
- WB: rf_we=1 and pc_we=1 for exactly this one cycle; retired increments. Next state is FETCH if en=1, else IDLE.
- HALT: terminal. rf_we and pc_we stay 0, illegal stays 1. Only rsta exits HALT.
- en deassertion mid-instruction (FETCH/DECODE/EXEC) has no effect until WB; the instruction always completes.
- Outputs are Moore (decode registers plus state); no combinational path from inst to any output.
- alu_op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, LUI=9.
- R-type decode (opcode 0x00; rf_dst_sel=1, alu_b_sel=0), by funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR
  - 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL
- I-type decode (rf_dst_sel=0, alu_b_sel=1), by opcode:
  - 0x08 ADDI (sext), 0x0A SLTI (sext)
  - 0x0C ANDI (zext), 0x0D ORI (zext), 0x0E XORI (zext)
  - 0x0F LUI (zext, alu_op=LUI)
- 0x00000000 decodes as SLL to $0; it is legal and retires normally (the register file ignores writes to $0).
- retired wraps from 2^RET_W-1 to 0 silently.
- Throughput: exactly 3+ROM_LAT cycles per instruction in continuous run. pc_we pulses are spaced 3+ROM_LAT cycles apart.

Test Plan:
- Reset, then en=1 with inst=0x00430820 (add $1,$2,$3) held -> states 1,2,3,4 repeating. In WB: rf_we=pc_we=1, rf_dst_sel=1, alu_op=0. retired=1 after the first WB and increments every 4 cycles.
- inst=0x3C01ABCD (lui), then 0x3421FFFF (ori) -> LUI: alu_b_sel=1, imm_zext=1, alu_op=9. ORI: alu_op=3, imm_zext=1, rf_dst_sel=0. Then 0x2001FFFF (addi) -> imm_zext=0, alu_op=0.
- inst=0xFC000000 (opcode 0x3F) -> illegal=1 and state=5 one cycle after DECODE. No rf_we/pc_we pulse for it; state stays HALT for 20 cycles; rsta clears illegal and returns to IDLE.
- Drop en during EXEC -> WB still completes (retired+1), then IDLE. Reassert en -> FETCH on the next edge.
- Assert rsta during EXEC -> immediate IDLE; rf_we/pc_we never pulse; retired=0 and ir=0.
- ROM_LAT=3, RET_W=4: 17 continuous instructions -> 6-cycle spacing between pc_we pulses; retired wraps 15->0 and reads 1 after the 17th WB.
